act_pipe_unit: RTL and testbench

//  Parametrised multi-mode activation stage for the vector engine: bypass, ReLU, leaky-ReLU
//  (arithmetic shift), clamped ReLU. BUS_NUM signed fixed-point lanes, per-lane valid mask.
//  2-stage pipeline with valid/ready backpressure; sits between the MAC/accumulate path and
//  the writeback/quantise path.

---
 rtl/act_pipe_if.sv | 29 ++
 rtl/act_pipe_unit.sv | 168 ++++++++++++++++
 tb/tb_act_pipe_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_pipe_if.sv
// Beat-level handshake bundle for act_pipe_unit: input beat, per-beat config and output beat.
interface act_pipe_if #(
  parameter int BUS_NUM          = 16,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int SHIFT_WIDTH      = 3,
  parameter int MODE_WIDTH       = 2
);
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] in_fixed_data;
  logic [BUS_NUM-1:0]                  in_fixed_data_vld;
  logic                                in_vld;
  logic                                in_rdy;
  logic [MODE_WIDTH-1:0]               act_mode;
  logic [SHIFT_WIDTH-1:0]              leak_shift;
  logic [FIXED_DATA_WIDTH-2:0]         clamp_val;
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] out_fixed_data;
  logic [BUS_NUM-1:0]                  out_fixed_data_vld;
  logic                                out_vld;
  logic                                out_rdy;

  modport master (
    output in_fixed_data, in_fixed_data_vld, in_vld, act_mode, leak_shift, clamp_val, out_rdy,
    input  in_rdy, out_fixed_data, out_fixed_data_vld, out_vld
  );

  modport slave (
    input  in_fixed_data, in_fixed_data_vld, in_vld, act_mode, leak_shift, clamp_val, out_rdy,
    output in_rdy, out_fixed_data, out_fixed_data_vld, out_vld
  );
endinterface

// File: rtl/act_pipe_unit.sv
// Two-stage activation pipeline (bypass / ReLU / leaky-ReLU / clamp) with valid/ready flow.
// Define ACT_STATS_EN to add the saturating negative/clamp lane counters and their ports.
module act_pipe_unit #(
  parameter int BUS_NUM          = 16,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int SHIFT_WIDTH      = 3,
  parameter int MODE_WIDTH       = 2,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef ACT_STATS_EN
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] stat_neg_cnt,
  output logic [CNT_WIDTH-1:0] stat_sat_cnt,
`endif
  act_pipe_if.slave            bus
);
  localparam int FDW = FIXED_DATA_WIDTH;
  localparam int PW  = $clog2(BUS_NUM + 1);

  typedef enum logic [MODE_WIDTH-1:0] {
    MODE_BYPASS = MODE_WIDTH'(0),
    MODE_RELU   = MODE_WIDTH'(1),
    MODE_LEAKY  = MODE_WIDTH'(2),
    MODE_CLAMP  = MODE_WIDTH'(3)
  } mode_e;

  logic                     s1_vld_q;
  logic [BUS_NUM*FDW-1:0]   s1_data_q;
  logic [BUS_NUM-1:0]       s1_mask_q;
  mode_e                    s1_mode_q;
  logic [SHIFT_WIDTH-1:0]   s1_shift_q;
  logic [FDW-2:0]           s1_clamp_q;

  logic                     out_vld_q;
  logic [BUS_NUM*FDW-1:0]   out_data_q;
  logic [BUS_NUM-1:0]       out_mask_q;
  logic [BUS_NUM*FDW-1:0]   res_d;

  logic                     s2_adv;
  logic                     s1_adv;
  logic                     accept;

  assign s2_adv = !out_vld_q || bus.out_rdy;
  assign s1_adv = !s1_vld_q || s2_adv;
  assign accept = bus.in_vld && s1_adv;

  assign bus.in_rdy             = s1_adv;
  assign bus.out_vld            = out_vld_q;
  assign bus.out_fixed_data     = out_data_q;
  assign bus.out_fixed_data_vld = out_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_mask_q  <= '0;
      s1_mode_q  <= MODE_BYPASS;
      s1_shift_q <= '0;
      s1_clamp_q <= '0;
    end else begin
      if (s1_adv) s1_vld_q <= bus.in_vld;
      if (accept) begin
        s1_data_q  <= bus.in_fixed_data;
        s1_mask_q  <= bus.in_fixed_data_vld;
        s1_mode_q  <= mode_e'(bus.act_mode);
        s1_shift_q <= bus.leak_shift;
        s1_clamp_q <= bus.clamp_val;
      end
    end
  end

  logic signed [FDW-1:0] x;
  logic signed [FDW-1:0] y;
  logic signed [FDW-1:0] ceil_s;
`ifdef ACT_STATS_EN
  logic [PW-1:0] neg_pop_d;
  logic [PW-1:0] sat_pop_d;
`endif

  always_comb begin
    res_d  = '0;
    x      = '0;
    y      = '0;
    ceil_s = {1'b0, s1_clamp_q};
`ifdef ACT_STATS_EN
    neg_pop_d = '0;
    sat_pop_d = '0;
`endif
    for (int unsigned i = 0; i < BUS_NUM; i++) begin
      x = s1_data_q[i*FDW +: FDW];
      y = x;
      case (s1_mode_q)
        MODE_RELU:  if (x[FDW-1]) y = '0;
        MODE_LEAKY: if (x[FDW-1]) y = x >>> s1_shift_q;
        MODE_CLAMP: begin
          if (x[FDW-1])       y = '0;
          else if (x > ceil_s) y = ceil_s;
        end
        default: ;
      endcase
      if (s1_mask_q[i]) begin
        res_d[i*FDW +: FDW] = y;
`ifdef ACT_STATS_EN
        if (x[FDW-1]) neg_pop_d = neg_pop_d + PW'(1);
        if (s1_mode_q == MODE_CLAMP && !x[FDW-1] && x > ceil_s) sat_pop_d = sat_pop_d + PW'(1);
`endif
      end
    end
  end

`ifdef ACT_STATS_EN
  logic [PW-1:0] out_neg_q;
  logic [PW-1:0] out_sat_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_mask_q <= '0;
`ifdef ACT_STATS_EN
      out_neg_q  <= '0;
      out_sat_q  <= '0;
`endif
    end else if (s2_adv) begin
      out_vld_q <= s1_vld_q;
      // Output data only reloads on a real beat so an idle output keeps its last value.
      if (s1_vld_q) begin
        out_data_q <= res_d;
        out_mask_q <= s1_mask_q;
`ifdef ACT_STATS_EN
        out_neg_q  <= neg_pop_d;
        out_sat_q  <= sat_pop_d;
`endif
      end
    end
  end

`ifdef ACT_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PW-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] neg_cnt_q;
  logic [CNT_WIDTH-1:0] sat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else if (stat_clr) begin
      neg_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else if (out_vld_q && bus.out_rdy) begin
      neg_cnt_q <= sat_add(neg_cnt_q, out_neg_q);
      sat_cnt_q <= sat_add(sat_cnt_q, out_sat_q);
    end
  end

  assign stat_neg_cnt = neg_cnt_q;
  assign stat_sat_cnt = sat_cnt_q;
`endif
endmodule

// File: tb/tb_act_pipe_unit.sv
// Randomised bench for act_pipe_unit: a beat-queue reference model checked every cycle,
// plus literal directed beats. Stats checks are included when ACT_STATS_EN is defined.
module tb_act_pipe_unit;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam int MW = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  act_pipe_if #(.BUS_NUM(N), .FIXED_DATA_WIDTH(W), .SHIFT_WIDTH(SW), .MODE_WIDTH(MW)) bus ();

`ifdef ACT_STATS_EN
  logic          stat_clr = 1'b0;
  logic [CW-1:0] stat_neg_cnt;
  logic [CW-1:0] stat_sat_cnt;
`endif

  act_pipe_unit #(
    .BUS_NUM(N), .FIXED_DATA_WIDTH(W), .SHIFT_WIDTH(SW), .MODE_WIDTH(MW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ACT_STATS_EN
    .stat_clr(stat_clr),
    .stat_neg_cnt(stat_neg_cnt),
    .stat_sat_cnt(stat_sat_cnt),
`endif
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference activation on plain integers; leaky uses floor division by 2^k.
  function automatic int act_ref(input int x, input int mode, input int sh, input int cl);
    int d;
    if (mode == 0) return x;
    if (x >= 0) return (mode == 3 && x > cl) ? cl : x;
    if (mode == 2) begin
      d = 1 << sh;
      return (x - (d - 1)) / d;
    end
    return 0;
  endfunction

  function automatic logic [N*W-1:0] pack(input int l3, input int l2, input int l1, input int l0);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  typedef struct {
    logic [N*W-1:0] d;
    logic [N-1:0]   m;
    int             acc;
    int             neg;
    int             sat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_hs = -100;
  int   nout = 0;
  logic [CW-1:0] mneg = '0;
  logic [CW-1:0] msat = '0;

  // Compare process: out_vld is due once the head beat is two edges past its accept and
  // one edge past the previous output handshake.
  always @(negedge clk) begin
    exp_t e;
    logic signed [W-1:0] lv;
    int   r, due;
    logic exp_vld, exp_rdy, hs, acc;
    cyc++;
    if (!rst_n) begin
      q.delete();
      last_hs = -100;
      mneg = '0;
      msat = '0;
      check("rst_out_vld", 64'(bus.out_vld), 64'(0));
      check("rst_out_data", 64'(bus.out_fixed_data), 64'(0));
      check("rst_out_mask", 64'(bus.out_fixed_data_vld), 64'(0));
`ifdef ACT_STATS_EN
      check("rst_stat_neg", 64'(stat_neg_cnt), 64'(0));
`endif
    end else begin
      exp_vld = 1'b0;
      if (q.size() > 0) begin
        due = (q[0].acc + 2 > last_hs + 1) ? q[0].acc + 2 : last_hs + 1;
        exp_vld = (cyc >= due);
      end
      check("out_vld", 64'(bus.out_vld), 64'(exp_vld));
      exp_rdy = !(q.size() == 2 && exp_vld && !bus.out_rdy);
      check("in_rdy", 64'(bus.in_rdy), 64'(exp_rdy));
      if (bus.out_vld && q.size() > 0) begin
        check("out_data", 64'(bus.out_fixed_data), 64'(q[0].d));
        check("out_mask", 64'(bus.out_fixed_data_vld), 64'(q[0].m));
      end
`ifdef ACT_STATS_EN
      check("stat_neg", 64'(stat_neg_cnt), 64'(mneg));
      check("stat_sat", 64'(stat_sat_cnt), 64'(msat));
`endif
      hs  = bus.out_vld && bus.out_rdy;
      acc = bus.in_vld && bus.in_rdy;
      if (hs && q.size() > 0) begin
`ifdef ACT_STATS_EN
        if (!stat_clr) begin
          mneg = mneg + CW'(q[0].neg);
          msat = msat + CW'(q[0].sat);
        end
`endif
        void'(q.pop_front());
        last_hs = cyc;
        nout++;
      end
`ifdef ACT_STATS_EN
      if (stat_clr) begin
        mneg = '0;
        msat = '0;
      end
`endif
      if (acc) begin
        e.d = '0;
        e.m = bus.in_fixed_data_vld;
        e.acc = cyc;
        e.neg = 0;
        e.sat = 0;
        for (int i = 0; i < N; i++) begin
          lv = bus.in_fixed_data[i*W +: W];
          if (e.m[i]) begin
            r = act_ref(int'(lv), int'(bus.act_mode), int'(bus.leak_shift), int'(bus.clamp_val));
            e.d[i*W +: W] = W'(r);
            if (lv < 0) e.neg++;
            if (bus.act_mode == 2'd3 && int'(lv) > int'(bus.clamp_val)) e.sat++;
          end
        end
        q.push_back(e);
      end
    end
  end

  task automatic directed(input string name, input logic [N*W-1:0] d, input logic [N-1:0] m,
                          input int mode, input int sh, input int cl,
                          input logic [N*W-1:0] ed, input logic [N-1:0] em);
    @(posedge clk); #1;
    bus.in_fixed_data     = d;
    bus.in_fixed_data_vld = m;
    bus.act_mode          = MW'(mode);
    bus.leak_shift        = SW'(sh);
    bus.clamp_val         = (W-1)'(cl);
    bus.out_rdy           = 1'b1;
    bus.in_vld            = 1'b1;
    check({name, "_in_rdy"}, 64'(bus.in_rdy), 64'(1));
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    check({name, "_vld_accept_edge"}, 64'(bus.out_vld), 64'(0));
    @(posedge clk); #1;
    check({name, "_vld_second_edge"}, 64'(bus.out_vld), 64'(1));
    check({name, "_data"}, 64'(bus.out_fixed_data), 64'(ed));
    check({name, "_mask"}, 64'(bus.out_fixed_data_vld), 64'(em));
    @(posedge clk); #1;
    check({name, "_vld_drained"}, 64'(bus.out_vld), 64'(0));
  endtask

  task automatic stream(input int n, input bit rand_rdy, input bit rand_idle, output int cycles);
    int  sent = 0;
    bit  pend = 0;
    cycles = 0;
    @(posedge clk); #1;
    while (sent < n && cycles < 2000) begin
      if (!pend) begin
        if (!rand_idle || $urandom_range(0, 3) != 0) begin
          bus.in_fixed_data     = $urandom;
          bus.in_fixed_data_vld = N'($urandom_range(0, 15));
          bus.act_mode          = MW'($urandom_range(0, 3));
          bus.leak_shift        = SW'($urandom_range(0, 7));
          bus.clamp_val         = (W-1)'($urandom_range(0, 127));
          bus.in_vld            = 1'b1;
          pend = 1;
        end else begin
          bus.in_vld = 1'b0;
        end
      end
      bus.out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (pend && bus.in_rdy) begin
        pend = 0;
        sent++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    bus.in_vld = 1'b0;
    check("stream_sent", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    int g = 0;
    bus.out_rdy = 1'b1;
    bus.in_vld  = 1'b0;
    while (q.size() > 0 && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int n0, g;
    bus.in_vld            = 1'b0;
    bus.in_fixed_data     = '0;
    bus.in_fixed_data_vld = '0;
    bus.act_mode          = '0;
    bus.leak_shift        = '0;
    bus.clamp_val         = '0;
    bus.out_rdy           = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_rdy", 64'(bus.in_rdy), 64'(1));
    check("post_reset_out_vld", 64'(bus.out_vld), 64'(0));

    directed("relu",   pack(-5, 0, 7, -128),    4'hf, 1, 0, 0, pack(0, 0, 7, 0),       4'hf);
    directed("leaky2", pack(-8, -1, -128, 12),  4'hf, 2, 2, 0, pack(-2, -1, -32, 12),  4'hf);
    directed("leaky0", pack(-8, -1, -128, 12),  4'hf, 2, 0, 0, pack(-8, -1, -128, 12), 4'hf);
    directed("leaky7", pack(-128, -1, 127, -2), 4'hf, 2, 7, 0, pack(-1, -1, 127, -1),  4'hf);
    directed("clamp",  pack(9, 6, -3, 5),       4'b1011, 3, 0, 6, pack(6, 0, 0, 5),    4'b1011);
    directed("bypass", pack(-1, 127, -128, 3),  4'b0110, 0, 5, 9, pack(0, 127, -128, 0), 4'b0110);
    directed("nomask", pack(1, 2, 3, 4),        4'b0000, 1, 0, 0, pack(0, 0, 0, 0),    4'b0000);

    n0 = nout;
    stream(10, 1'b1, 1'b0, g);
    drain();
    check("backpressure_count", 64'(nout - n0), 64'(10));

    n0 = nout;
    stream(20, 1'b0, 1'b0, g);
    check("fullrate_cycles", 64'(g), 64'(20));
    drain();
    check("fullrate_count", 64'(nout - n0), 64'(20));

    stream(80, 1'b1, 1'b1, g);
    drain();

    fork
      stream(30, 1'b1, 1'b1, g);
      begin
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_vld", 64'(bus.out_vld), 64'(0));
        check("midrst_out_data", 64'(bus.out_fixed_data), 64'(0));
        check("midrst_out_mask", 64'(bus.out_fixed_data_vld), 64'(0));
        check("midrst_in_rdy", 64'(bus.in_rdy), 64'(1));
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    join
    drain();

`ifdef ACT_STATS_EN
    @(posedge clk); #3 rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    directed("st_relu",  pack(-5, 0, 7, -128), 4'hf,    1, 0, 0, pack(0, 0, 7, 0), 4'hf);
    directed("st_clamp", pack(9, 6, -3, 5),    4'b1011, 3, 0, 6, pack(6, 0, 0, 5), 4'b1011);
    @(posedge clk); #1;
    check("stats_neg_lit", 64'(stat_neg_cnt), 64'(3));
    check("stats_sat_lit", 64'(stat_sat_cnt), 64'(1));
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stats_neg_clr", 64'(stat_neg_cnt), 64'(0));
    check("stats_sat_clr", 64'(stat_sat_cnt), 64'(0));
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
